// File: rtl/line_framebuffer.sv
// Frame store between the line drawer and the video driver: one write port, one
// registered read port, and a clear engine that sweeps every pixel to a fixed value.
module line_framebuffer #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned DATA_W = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [9:0]        wr_x,
  input  logic [8:0]        wr_y,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [9:0]        rd_x,
  input  logic [8:0]        rd_y,
  output logic [DATA_W-1:0] rd_data,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_value,
  output logic              busy,
  output logic              clear_done
);

  localparam int unsigned Depth    = WIDTH * HEIGHT;
  localparam logic [18:0] LastAddr = 19'(Depth - 1);
  localparam logic [9:0]  XLim     = 10'(WIDTH);
  localparam logic [8:0]  YLim     = 9'(HEIGHT);

  typedef enum logic {StIdle, StClear} state_e;

  state_e              state_q;
  logic [18:0]         clr_addr_q;
  logic [DATA_W-1:0]   clr_val_q;
  logic                busy_q;
  logic                done_q;

  logic [DATA_W-1:0]   mem [Depth];
  logic                mem_we;
  logic [18:0]         mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                wr_in_range;
  logic                rd_in_range;
  logic [18:0]         rd_addr;
  logic [DATA_W-1:0]   rd_raw_q;
  logic                rd_ok_q;

  // 640 = 512 + 128, so the default geometry needs only two shifts and adds.
  function automatic logic [18:0] pix_addr(input logic [9:0] x, input logic [8:0] y);
    logic [18:0] x19;
    logic [18:0] y19;
    x19 = {9'd0, x};
    y19 = {10'd0, y};
    if (WIDTH == 640) begin
      return (y19 << 9) + (y19 << 7) + x19;
    end else begin
      return (y19 * 19'(WIDTH)) + x19;
    end
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      clr_addr_q <= '0;
      clr_val_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      busy_q <= (state_q == StClear);
      // busy still high while the FSM is already idle marks the cycle after the last write
      done_q <= busy_q && (state_q == StIdle);
      unique case (state_q)
        StIdle: begin
          if (clear_start) begin
            state_q    <= StClear;
            clr_addr_q <= '0;
            clr_val_q  <= clear_value;
          end
        end
        StClear: begin
          if (clr_addr_q == LastAddr) begin
            clr_addr_q <= '0;
            state_q    <= StIdle;
          end else begin
            clr_addr_q <= clr_addr_q + 19'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wr_in_range = (wr_x < XLim) && (wr_y < YLim);
  assign rd_in_range = (rd_x < XLim) && (rd_y < YLim);
  assign rd_addr     = rd_in_range ? pix_addr(rd_x, rd_y) : '0;

  // Clear engine owns the write port; drawer writes are dropped until busy falls.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = pix_addr(wr_x, wr_y);
    mem_wdata = wr_data;
    if (state_q == StClear) begin
      mem_we    = !reset;
      mem_waddr = clr_addr_q;
      mem_wdata = clr_val_q;
    end else if (wr_en && !busy_q && wr_in_range) begin
      mem_we = !reset;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    rd_raw_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ok_q <= 1'b0;
    end else begin
      rd_ok_q <= rd_in_range;
    end
  end

  assign rd_data    = rd_ok_q ? rd_raw_q : '0;
  assign busy       = busy_q;
  assign clear_done = done_q;

endmodule

// File: tb/tb_line_framebuffer.sv
// Scoreboard bench for line_framebuffer on a reduced 16x12 frame so clears stay short.
module tb_line_framebuffer;

  localparam int unsigned W     = 16;
  localparam int unsigned H     = 12;
  localparam int unsigned DEPTH = W * H;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [9:0] wr_x = '0;
  logic [8:0] wr_y = '0;
  logic [0:0] wr_data = '0;
  logic [9:0] rd_x = '0;
  logic [8:0] rd_y = '0;
  logic [0:0] rd_data;
  logic       clear_start = 1'b0;
  logic [0:0] clear_value = '0;
  logic       busy;
  logic       clear_done;

  always #5 clk = ~clk;

  line_framebuffer #(
    .WIDTH (W),
    .HEIGHT(H),
    .DATA_W(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_data    (wr_data),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_data    (rd_data),
    .clear_start(clear_start),
    .clear_value(clear_value),
    .busy       (busy),
    .clear_done (clear_done)
  );

  int         n_checks = 0;
  int         n_pass = 0;
  logic [0:0] exp_q[$];
  string      name_q[$];
  logic       rd_tag = 1'b0;
  logic [0:0] m_exp;
  string      m_name;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: a tagged read address sampled at an edge yields rd_data just after it.
  always @(posedge clk) begin
    if (rd_tag) begin
      #1;
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 1, 0);
      end else begin
        m_exp  = exp_q.pop_front();
        m_name = name_q.pop_front();
        check(m_name, int'(rd_data), int'(m_exp));
      end
    end
  end

  task automatic read_exp(input int x, input int y, input logic [0:0] exp, input string name);
    @(negedge clk);
    rd_x   = 10'(x);
    rd_y   = 9'(y);
    rd_tag = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(negedge clk);
    rd_tag = 1'b0;
  endtask

  task automatic write_px(input int x, input int y, input logic [0:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_x    = 10'(x);
    wr_y    = 9'(y);
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Runs one clear; optionally injects a write+restart or a reset at clear cycle k.
  task automatic do_clear(input logic [0:0] val, input int restart_at, input int reset_at,
                          input int exp_busy, input int exp_done, input string tag);
    int bc;
    int dc;
    int done_at;
    bc = 0;
    dc = 0;
    done_at = 0;
    @(negedge clk);
    clear_start = 1'b1;
    clear_value = val;
    @(posedge clk);
    #1;
    check({tag, "_busy_lag"}, int'(busy), 0);
    @(negedge clk);
    clear_start = 1'b0;
    clear_value = ~val;
    for (int k = 1; k <= int'(DEPTH) + 8; k++) begin
      @(posedge clk);
      #1;
      if (busy) bc++;
      if (clear_done) begin
        dc++;
        done_at = k;
      end
      if (reset_at > 0 && k == reset_at + 1) check({tag, "_busy_after_reset"}, int'(busy), 0);
      @(negedge clk);
      wr_en       = (k == restart_at);
      wr_x        = 10'(W - 1);
      wr_y        = 9'(H - 1);
      wr_data     = ~val;
      clear_start = (k == restart_at);
      reset       = (k == reset_at);
    end
    wr_en       = 1'b0;
    clear_start = 1'b0;
    reset       = 1'b0;
    check({tag, "_busy_cycles"}, bc, exp_busy);
    check({tag, "_done_pulses"}, dc, exp_done);
    if (exp_done > 0) check({tag, "_done_cycle"}, done_at, int'(DEPTH) + 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_rd_data", int'(rd_data), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_clear_done", int'(clear_done), 0);

    do_clear(1'b0, 0, 0, DEPTH, 1, "clr0");
    read_exp(0, 0, 1'b0, "clr0_px_0_0");
    read_exp(W - 1, H - 1, 1'b0, "clr0_px_last");
    read_exp(8, 6, 1'b0, "clr0_px_mid");

    write_px(5, 7, 1'b1);
    read_exp(5, 7, 1'b1, "wr_px_5_7");
    read_exp(6, 7, 1'b0, "neighbour_px_6_7");

    write_px(W, 0, 1'b1);
    write_px(0, H, 1'b1);
    read_exp(0, 1, 1'b0, "oor_x_no_wrap");
    read_exp(0, 0, 1'b0, "oor_y_no_wrap");

    // Write and read the same pixel in one cycle, then re-read.
    @(negedge clk);
    wr_en   = 1'b1;
    wr_x    = 10'd10;
    wr_y    = 9'd10;
    wr_data = 1'b1;
    rd_x    = 10'd10;
    rd_y    = 9'd10;
    rd_tag  = 1'b1;
    exp_q.push_back(1'b0);
    name_q.push_back("collision_old");
    @(negedge clk);
    wr_en = 1'b0;
    exp_q.push_back(1'b1);
    name_q.push_back("collision_new");
    @(negedge clk);
    rd_tag = 1'b0;

    do_clear(1'b1, 100, 0, DEPTH, 1, "clr1_restart");
    read_exp(W - 1, H - 1, 1'b1, "clr1_last_write_dropped");
    read_exp(6, 7, 1'b1, "clr1_px_6_7");
    read_exp(W, 0, 1'b0, "oor_read_x");
    read_exp(0, H, 1'b0, "oor_read_y");

    do_clear(1'b0, 0, 50, 50, 0, "clr_reset");
    read_exp(1, 3, 1'b0, "partial_cleared");
    read_exp(2, 3, 1'b1, "partial_untouched");
    read_exp(W - 1, H - 1, 1'b1, "partial_last");

    do_clear(1'b0, 0, 0, DEPTH, 1, "clr_after_reset");
    read_exp(W - 1, H - 1, 1'b0, "full_last");
    read_exp(2, 3, 1'b0, "full_px_2_3");

    repeat (3) @(negedge clk);
    check("scoreboard_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
